mdio_controller: RTL and testbench

- Station-management (STA) side MDIO master. It sits directly upstream of the PHY-side mdio_receptor.
- Accepts a 32-bit Clause-22 transaction word, generates MDC, and serializes the frame MSB-first onto MDIO_OUT with MDIO_OE.
- For reads, it releases the bus after the register address, then captures 16 data bits from MDIO_IN into RD_DATA.

---
 rtl/mdio_controller.sv | 235 +++++++++++++++++++++++
 tb/tb_mdio_controller.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_controller.sv
`default_nettype none
// ============================================================================
//  Module      : mdio_controller
//  Description : Clause-22 MDIO station-management master. Generates a
//                free-running MDC from CLK, serializes a 32-bit transaction
//                word MSB-first on MDIO_OUT/MDIO_OE on MDC falling events,
//                and for reads releases the bus after the register address
//                and captures 16 data bits from MDIO_IN on MDC rising events.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    HALF_PERIOD  CLK cycles per MDC half-period (1..255)
//  Optional build macro
//    MDIO_PREAMBLE_EN  when defined, 32 preamble ones precede every frame
//  Ports
//    CLK         in   system clock, all logic on posedge
//    RESET       in   asynchronous active-low reset
//    MDIO_START  in   one-CLK request, accepted only in IDLE
//    T_DATA      in   [31:30] ST [29:28] OP [27:23] PHYAD [22:18] REGAD
//                     [17:16] TA [15:0] write data; latched at acceptance
//    MDIO_IN     in   serial data returned by the PHY during reads
//    MDC         out  management clock
//    MDIO_OUT    out  serial frame bit
//    MDIO_OE     out  1 = controller drives the bus
//    RD_DATA     out  last read result
//    DATA_RDY    out  one-CLK pulse when RD_DATA is updated
//    MDIO_DONE   out  one-CLK pulse at the end of any transaction
//    BUSY        out  high from accepted START until MDIO_DONE
// ============================================================================
module mdio_controller #(
    parameter int HALF_PERIOD = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MDIO_START,
    input  logic [31:0] T_DATA,
    input  logic        MDIO_IN,
    output logic        MDC,
    output logic        MDIO_OUT,
    output logic        MDIO_OE,
    output logic [15:0] RD_DATA,
    output logic        DATA_RDY,
    output logic        MDIO_DONE,
    output logic        BUSY
);

    localparam logic [7:0] DIV_LAST = 8'(HALF_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT     = 3'd1,
        PREAMBLE = 3'd2,
        SHIFT    = 3'd3,
        TA       = 3'd4,
        READ     = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // MDC divider: runs continuously, independent of the frame FSM.
    // ------------------------------------------------------------------
    logic [7:0] div_cnt;
    logic       tick;
    logic       fall_ev;
    logic       rise_ev;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            div_cnt <= 8'd0;
            MDC     <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= 8'd0;
            MDC     <= ~MDC;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

    assign tick    = (div_cnt == DIV_LAST);
    assign fall_ev = tick & MDC;
    assign rise_ev = tick & ~MDC;

    // ------------------------------------------------------------------
    // Frame FSM. bit_idx holds the index of the frame bit most recently
    // presented on the bus (or the preamble count while in PREAMBLE).
    // ------------------------------------------------------------------
    state_t      state,     state_n;
    logic [4:0]  bit_idx,   bit_idx_n;
    logic [31:0] tx_word,   tx_word_n;
    logic [15:0] rx_shift,  rx_shift_n;
    logic [15:0] rd_data_n;
    logic        out_n, oe_n, busy_n, done_n, rdy_n;
    logic [4:0]  bit_inc;
    logic        is_read;

    assign bit_inc = bit_idx + 5'd1;
    assign is_read = (tx_word[29:28] == 2'b10);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            bit_idx   <= 5'd0;
            tx_word   <= 32'd0;
            rx_shift  <= 16'd0;
            RD_DATA   <= 16'd0;
            MDIO_OUT  <= 1'b0;
            MDIO_OE   <= 1'b0;
            BUSY      <= 1'b0;
            MDIO_DONE <= 1'b0;
            DATA_RDY  <= 1'b0;
        end else begin
            state     <= state_n;
            bit_idx   <= bit_idx_n;
            tx_word   <= tx_word_n;
            rx_shift  <= rx_shift_n;
            RD_DATA   <= rd_data_n;
            MDIO_OUT  <= out_n;
            MDIO_OE   <= oe_n;
            BUSY      <= busy_n;
            MDIO_DONE <= done_n;
            DATA_RDY  <= rdy_n;
        end
    end

    always_comb begin
        state_n    = state;
        bit_idx_n  = bit_idx;
        tx_word_n  = tx_word;
        rx_shift_n = rx_shift;
        rd_data_n  = RD_DATA;
        out_n      = MDIO_OUT;
        oe_n       = MDIO_OE;
        busy_n     = BUSY;
        done_n     = 1'b0;
        rdy_n      = 1'b0;

        case (state)
            IDLE: begin
                // The cycle carrying the DONE pulse is already IDLE, but a
                // START there must still be ignored.
                if (MDIO_START && !MDIO_DONE) begin
                    tx_word_n = T_DATA;
                    busy_n    = 1'b1;
                    bit_idx_n = 5'd0;
                    state_n   = WAIT;
                end
            end

            WAIT: begin
                if (fall_ev) begin
                    oe_n      = 1'b1;
                    bit_idx_n = 5'd0;
`ifdef MDIO_PREAMBLE_EN
                    out_n     = 1'b1;
                    state_n   = PREAMBLE;
`else
                    out_n     = tx_word[31];
                    state_n   = SHIFT;
`endif
                end
            end

            PREAMBLE: begin
                if (fall_ev) begin
                    if (bit_idx == 5'd31) begin
                        out_n     = tx_word[31];
                        bit_idx_n = 5'd0;
                        state_n   = SHIFT;
                    end else begin
                        out_n     = 1'b1;
                        bit_idx_n = bit_inc;
                    end
                end
            end

            SHIFT: begin
                if (fall_ev) begin
                    if (bit_idx == 5'd31) begin
                        // Write complete: this is the falling event after
                        // the last data bit.
                        out_n   = 1'b0;
                        oe_n    = 1'b0;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        state_n = IDLE;
                    end else if (is_read && (bit_idx == 5'd13)) begin
                        // Register address done: release for turnaround.
                        out_n     = 1'b0;
                        oe_n      = 1'b0;
                        bit_idx_n = 5'd14;
                        state_n   = TA;
                    end else begin
                        out_n     = tx_word[5'd31 - bit_inc];
                        bit_idx_n = bit_inc;
                    end
                end
            end

            TA: begin
                if (fall_ev) begin
                    bit_idx_n = bit_inc;
                    if (bit_idx == 5'd15) begin
                        state_n = READ;
                    end
                end
            end

            READ: begin
                // First sample lands in the LSB and ends up as RD_DATA[15]
                // after all sixteen shifts.
                if (rise_ev) begin
                    rx_shift_n = {rx_shift[14:0], MDIO_IN};
                end
                if (fall_ev) begin
                    if (bit_idx == 5'd31) begin
                        out_n     = 1'b0;
                        oe_n      = 1'b0;
                        done_n    = 1'b1;
                        busy_n    = 1'b0;
                        rd_data_n = rx_shift;
                        rdy_n     = 1'b1;
                        state_n   = IDLE;
                    end else begin
                        bit_idx_n = bit_inc;
                    end
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mdio_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdio_controller
//  Description : Self-checking bench for mdio_controller. Two instances are
//                used, HALF_PERIOD=1 (index 0) and HALF_PERIOD=3 (index 1).
//                A behavioural model derives the expected serial stream,
//                done position and read result from the transaction word.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdio_controller;

`ifdef MDIO_PREAMBLE_EN
    localparam int PRE = 32;
`else
    localparam int PRE = 0;
`endif

    logic        CLK;
    logic        rst_n;
    logic        start0, start1, in0, in1;
    logic [31:0] td0, td1;
    logic        mdc0, out0, oe0, rdy0, done0, busy0;
    logic        mdc1, out1, oe1, rdy1, done1, busy1;
    logic [15:0] rd0, rd1;

    int total = 0;
    int bad   = 0;

    mdio_controller #(.HALF_PERIOD(1)) u_dut0 (
        .CLK(CLK), .RESET(rst_n), .MDIO_START(start0), .T_DATA(td0),
        .MDIO_IN(in0), .MDC(mdc0), .MDIO_OUT(out0), .MDIO_OE(oe0),
        .RD_DATA(rd0), .DATA_RDY(rdy0), .MDIO_DONE(done0), .BUSY(busy0)
    );

    mdio_controller #(.HALF_PERIOD(3)) u_dut1 (
        .CLK(CLK), .RESET(rst_n), .MDIO_START(start1), .T_DATA(td1),
        .MDIO_IN(in1), .MDC(mdc1), .MDIO_OUT(out1), .MDIO_OE(oe1),
        .RD_DATA(rd1), .DATA_RDY(rdy1), .MDIO_DONE(done1), .BUSY(busy1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // Snapshot of the selected DUT
    logic        s_mdc, s_out, s_oe, s_rdy, s_done, s_busy;
    logic [15:0] s_rd;

    // Results of the last transaction
    logic [63:0] r_stream;
    int          r_len, r_falls, r_done_cnt, r_done_fall, r_done_cyc, r_first_cyc;
    int          r_rdy_cnt, r_busy_bad, r_hold_bad, r_period_bad, r_after_bad, r_out_bad;
    logic        r_rdy_at_done;
    logic [15:0] r_rd_at_done;

    task automatic snap(input int d);
        if (d == 0) begin
            s_mdc = mdc0; s_out = out0; s_oe = oe0; s_rdy = rdy0;
            s_done = done0; s_busy = busy0; s_rd = rd0;
        end else begin
            s_mdc = mdc1; s_out = out1; s_oe = oe1; s_rdy = rdy1;
            s_done = done1; s_busy = busy1; s_rd = rd1;
        end
    endtask

    task automatic drive(input int d, input logic st, input logic [31:0] td, input logic mi);
        if (d == 0) begin start0 = st; td0 = td; in0 = mi; end
        else        begin start1 = st; td1 = td; in1 = mi; end
    endtask

    // Expected bus content at consecutive driven MDC periods: preamble ones,
    // then the whole word for a write, or ST/OP/PHYAD/REGAD for a read.
    task automatic model_stream(input logic [31:0] w, output logic [63:0] v, output int n);
        int last;
        v = 64'd0;
        n = 0;
        last = (w[29:28] == 2'b10) ? 18 : 0;
        for (int i = 0; i < PRE; i++) begin v = {v[62:0], 1'b1}; n++; end
        for (int i = 31; i >= last; i--) begin v = {v[62:0], w[i]}; n++; end
    endtask

    // Runs one transaction on DUT d, playing the PHY for reads, and records
    // what appeared on the bus. Optionally re-asserts START with another word
    // right after falling event dup_fall, or during the DONE cycle.
    task automatic run_txn(input int d, input logic [31:0] word, input logic [15:0] phy,
                           input int dup_fall, input logic [31:0] dup_word, input bit start_on_done);
        int hp, limit, last_fall, post;
        logic prev_mdc, last_out, st, mi, fall;
        logic [31:0] td;
        bit done_seen;
        hp = (d == 0) ? 1 : 3;
        limit = (PRE + 34) * 2 * hp + 8 * hp + 20;
        r_stream = 64'd0; r_len = 0; r_falls = 0; r_done_cnt = 0; r_done_fall = -1;
        r_done_cyc = -1; r_first_cyc = -1; r_rdy_cnt = 0; r_busy_bad = 0; r_hold_bad = 0;
        r_period_bad = 0; r_after_bad = 0; r_out_bad = 0; r_rdy_at_done = 1'b0; r_rd_at_done = 16'd0;
        last_fall = -1; post = 0; done_seen = 0; last_out = 1'b0; mi = 1'b0;
        @(negedge CLK);
        snap(d);
        prev_mdc = s_mdc;
        last_out = s_out;
        drive(d, 1'b1, word, mi);
        for (int c = 1; c <= limit; c++) begin
            @(negedge CLK);
            snap(d);
            st = 1'b0;
            td = $urandom;
            // A fall on the acceptance edge itself belongs to no frame.
            fall = (c > 1) && prev_mdc && !s_mdc;
            if (fall) begin
                r_falls++;
                if (last_fall > 0 && (c - last_fall) != 2 * hp) r_period_bad++;
                last_fall = c;
                if (s_oe) begin r_stream = {r_stream[62:0], s_out}; r_len++; end
                last_out = s_out;
                if (r_falls >= PRE + 17 && r_falls <= PRE + 32) mi = phy[PRE + 32 - r_falls];
                else mi = 1'($urandom);
                if (r_falls == dup_fall) begin st = 1'b1; td = dup_word; end
            end else if (s_out !== last_out) begin
                r_hold_bad++;
            end
            if (!s_oe && s_out) r_out_bad++;
            if (s_oe && r_first_cyc < 0) r_first_cyc = c;
            if (s_rdy) r_rdy_cnt++;
            if (s_done) begin
                r_done_cnt++;
                if (!done_seen) begin
                    r_done_fall = r_falls; r_done_cyc = c;
                    r_rdy_at_done = s_rdy; r_rd_at_done = s_rd;
                    if (s_busy) r_busy_bad++;
                end
                done_seen = 1;
                if (start_on_done) st = 1'b1;
            end else if (done_seen) begin
                if (s_busy || s_oe) r_after_bad++;
                post++;
            end else if (!s_busy) begin
                r_busy_bad++;
            end
            prev_mdc = s_mdc;
            drive(d, st, td, mi);
            if (post >= 4 * hp + 4) break;
        end
        drive(d, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic test_reset();
        int t0, t1;
        logic p0, p1;
        rst_n = 1'b0;
        drive(0, 1'b0, 32'd0, 1'b0);
        drive(1, 1'b0, 32'd0, 1'b0);
        repeat (3) @(negedge CLK);
        total++;
        if ({mdc0, out0, oe0, rdy0, done0, busy0, rd0} !== 22'd0) begin
            bad++;
            $display("FAIL reset_dut0: got %h required 0", {mdc0, out0, oe0, rdy0, done0, busy0, rd0});
        end
        total++;
        if ({mdc1, out1, oe1, rdy1, done1, busy1, rd1} !== 22'd0) begin
            bad++;
            $display("FAIL reset_dut1: got %h required 0", {mdc1, out1, oe1, rdy1, done1, busy1, rd1});
        end
        rst_n = 1'b1;
        t0 = 0; t1 = 0; p0 = mdc0; p1 = mdc1;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            if (c < 4 && mdc0 !== p0) t0++;
            if (mdc1 !== p1) t1++;
            p0 = mdc0; p1 = mdc1;
        end
        total++;
        if (t0 != 4 || t1 != 2) begin
            bad++;
            $display("FAIL mdc_divider: got toggles %0d/%0d required 4/2", t0, t1);
        end
        total++;
        if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
            bad++;
            $display("FAIL idle_busy: got %b%b required 00", busy0, busy1);
        end
    endtask

    task automatic test_write();
        logic [63:0] ev; int en;
        run_txn(0, 32'h53AE43AE, 16'h0, -1, 32'h0, 1'b0);
        model_stream(32'h53AE43AE, ev, en);
        total++;
        if (r_len != en || r_stream !== ev) begin
            bad++;
            $display("FAIL write_stream: got len=%0d %h required len=%0d %h", r_len, r_stream, en, ev);
        end
        total++;
        if (r_done_cnt != 1 || r_done_fall != PRE + 33) begin
            bad++;
            $display("FAIL write_done: got count=%0d fall=%0d required 1 at %0d", r_done_cnt, r_done_fall, PRE + 33);
        end
        total++;
        if (r_rdy_cnt != 0) begin
            bad++;
            $display("FAIL write_rdy: got %0d pulses required 0", r_rdy_cnt);
        end
        total++;
        if (r_first_cyc < 1 || r_first_cyc > 3) begin
            bad++;
            $display("FAIL write_first_bit: got cycle %0d required 1..3", r_first_cyc);
        end
        total++;
        if (r_busy_bad + r_hold_bad + r_period_bad + r_after_bad + r_out_bad != 0) begin
            bad++;
            $display("FAIL write_protocol: got busy=%0d hold=%0d period=%0d after=%0d out=%0d required all 0",
                     r_busy_bad, r_hold_bad, r_period_bad, r_after_bad, r_out_bad);
        end
    endtask

    task automatic test_read();
        logic [63:0] ev; int en;
        run_txn(0, 32'h61AE0000, 16'h43AE, -1, 32'h0, 1'b0);
        model_stream(32'h61AE0000, ev, en);
        total++;
        if (r_len != en || r_stream !== ev) begin
            bad++;
            $display("FAIL read_stream: got len=%0d %h required len=%0d %h", r_len, r_stream, en, ev);
        end
        total++;
        if (r_rd_at_done !== 16'h43AE || r_rdy_at_done !== 1'b1) begin
            bad++;
            $display("FAIL read_data: got %h rdy=%b required 43ae rdy=1", r_rd_at_done, r_rdy_at_done);
        end
        total++;
        if (r_done_cnt != 1 || r_rdy_cnt != 1 || r_done_fall != PRE + 33) begin
            bad++;
            $display("FAIL read_pulses: got done=%0d rdy=%0d fall=%0d required 1 1 %0d",
                     r_done_cnt, r_rdy_cnt, r_done_fall, PRE + 33);
        end
        total++;
        if (r_busy_bad + r_hold_bad + r_period_bad + r_after_bad + r_out_bad != 0) begin
            bad++;
            $display("FAIL read_protocol: got busy=%0d hold=%0d period=%0d after=%0d out=%0d required all 0",
                     r_busy_bad, r_hold_bad, r_period_bad, r_after_bad, r_out_bad);
        end
        run_txn(0, 32'h5C1F0BEE, 16'h0, -1, 32'h0, 1'b0);
        total++;
        if (rd0 !== 16'h43AE || r_rdy_cnt != 0) begin
            bad++;
            $display("FAIL read_hold: got %h rdy=%0d required 43ae rdy=0", rd0, r_rdy_cnt);
        end
    endtask

    task automatic test_busy_start();
        logic [63:0] ev; int en;
        run_txn(0, 32'h53AE43AE, 16'h0, PRE + 6, 32'h6BCD1234, 1'b0);
        model_stream(32'h53AE43AE, ev, en);
        total++;
        if (r_len != en || r_stream !== ev || r_done_cnt != 1) begin
            bad++;
            $display("FAIL busy_start: got len=%0d %h done=%0d required len=%0d %h done=1",
                     r_len, r_stream, r_done_cnt, en, ev);
        end
    endtask

    task automatic test_start_on_done();
        run_txn(0, 32'h5A5A00FF, 16'h0, -1, 32'h0, 1'b1);
        total++;
        if (r_done_cnt != 1 || r_after_bad != 0) begin
            bad++;
            $display("FAIL start_on_done: got done=%0d after=%0d required 1 0", r_done_cnt, r_after_bad);
        end
    endtask

    task automatic test_half_period3();
        logic [63:0] ev; int en;
        run_txn(1, 32'h53AE43AE, 16'h0, -1, 32'h0, 1'b0);
        model_stream(32'h53AE43AE, ev, en);
        total++;
        if (r_len != en || r_stream !== ev) begin
            bad++;
            $display("FAIL hp3_stream: got len=%0d %h required len=%0d %h", r_len, r_stream, en, ev);
        end
        total++;
        if (r_period_bad != 0 || r_hold_bad != 0 || r_first_cyc < 1 || r_first_cyc > 7) begin
            bad++;
            $display("FAIL hp3_timing: got period=%0d hold=%0d first=%0d required 0 0 1..7",
                     r_period_bad, r_hold_bad, r_first_cyc);
        end
        total++;
        if (r_done_cnt != 1 || r_done_fall != PRE + 33 || r_done_cyc < 1 || r_done_cyc > (PRE + 33) * 6 + 2) begin
            bad++;
            $display("FAIL hp3_done: got count=%0d fall=%0d cycle=%0d required 1 %0d <=%0d",
                     r_done_cnt, r_done_fall, r_done_cyc, PRE + 33, (PRE + 33) * 6 + 2);
        end
    endtask

    task automatic test_reset_mid();
        int falls, seen_done, seen_busy;
        logic prev;
        bit got;
        logic [63:0] ev; int en;
        @(negedge CLK);
        start0 = 1'b1; td0 = 32'h53AE43AE;
        prev = mdc0; falls = 0; got = 0;
        for (int c = 1; c <= 400 && !got; c++) begin
            @(negedge CLK);
            start0 = 1'b0;
            if (c > 1 && prev && !mdc0) falls++;
            prev = mdc0;
            if (falls == PRE + 11) got = 1;
        end
        total++;
        if (!got || oe0 !== 1'b1 || busy0 !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_reach: got reached=%0d oe=%b busy=%b required 1 1 1", got, oe0, busy0);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({mdc0, out0, oe0, rdy0, done0, busy0, rd0} !== 22'd0) begin
            bad++;
            $display("FAIL reset_mid_outputs: got %h required 0", {mdc0, out0, oe0, rdy0, done0, busy0, rd0});
        end
        seen_done = 0; seen_busy = 0;
        repeat (3) begin @(negedge CLK); if (done0) seen_done++; end
        rst_n = 1'b1;
        repeat (6) begin @(negedge CLK); if (done0) seen_done++; if (busy0) seen_busy++; end
        total++;
        if (seen_done != 0 || seen_busy != 0) begin
            bad++;
            $display("FAIL reset_mid_after: got done=%0d busy=%0d required 0 0", seen_done, seen_busy);
        end
        run_txn(0, 32'h5F0012A5, 16'h0, -1, 32'h0, 1'b0);
        model_stream(32'h5F0012A5, ev, en);
        total++;
        if (r_len != en || r_stream !== ev || r_done_cnt != 1) begin
            bad++;
            $display("FAIL reset_mid_restart: got len=%0d %h done=%0d required len=%0d %h done=1",
                     r_len, r_stream, r_done_cnt, en, ev);
        end
    endtask

    task automatic test_random();
        logic [63:0] ev; int en, d;
        logic [31:0] w;
        logic [15:0] phy, exp_rd;
        bit rd;
        for (int it = 0; it < 10; it++) begin
            d = int'($urandom_range(0, 1));
            w = $urandom;
            phy = 16'($urandom);
            rd = ($urandom_range(0, 1) == 1);
            if (rd) w[29:28] = 2'b10;
            else if (w[29:28] == 2'b10) w[29:28] = 2'b01;
            exp_rd = rd ? phy : ((d == 0) ? rd0 : rd1);
            run_txn(d, w, phy, -1, 32'h0, 1'b0);
            model_stream(w, ev, en);
            total++;
            if (r_len != en || r_stream !== ev) begin
                bad++;
                $display("FAIL rand_stream[%0d]: got len=%0d %h required len=%0d %h", it, r_len, r_stream, en, ev);
            end
            total++;
            if (r_done_cnt != 1 || r_done_fall != PRE + 33 || r_rdy_cnt != (rd ? 1 : 0)) begin
                bad++;
                $display("FAIL rand_done[%0d]: got done=%0d fall=%0d rdy=%0d required 1 %0d %0d",
                         it, r_done_cnt, r_done_fall, r_rdy_cnt, PRE + 33, rd ? 1 : 0);
            end
            total++;
            if (((d == 0) ? rd0 : rd1) !== exp_rd) begin
                bad++;
                $display("FAIL rand_rd[%0d]: got %h required %h", it, (d == 0) ? rd0 : rd1, exp_rd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_busy_start();
        test_start_on_done();
        test_half_period3();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
